// File: rtl/mem_array_if.sv
// rtl/mem_array_if.sv - request/response bundle between a bus master and mem_array
interface mem_array_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [WIDTH-1:0]      wdata_i;
  logic                  wr_rd_i;
  logic                  valid_i;
  logic [WIDTH-1:0]      rdata_o;
  logic                  ready_o;

  modport master (
    output addr_i, wdata_i, wr_rd_i, valid_i,
    input  rdata_o, ready_o
  );

  modport slave (
    input  addr_i, wdata_i, wr_rd_i, valid_i,
    output rdata_o, ready_o
  );
endinterface

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM with valid/ready requests
// Optional: MEM_CLEAR_EN zeroes every word after each reset release.
module mem_array #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mem_array_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RST,
`ifdef MEM_CLEAR_EN
    ST_CLEAR,
`endif
    ST_RDY
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata;
  logic             ready;
  logic             in_range;
  logic             accept;

`ifdef MEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_last;
  assign clr_last = ({1'b0, clr_addr} == DEPTH_W - 1'b1);
`endif

  // Widened compare keeps the range check meaningful when DEPTH == 2**ADDR_WIDTH.
  assign in_range = ({1'b0, bus.addr_i} < DEPTH_W);
  assign accept   = bus.valid_i && ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RST;
      ready <= 1'b0;
      rdata <= '0;
`ifdef MEM_CLEAR_EN
      clr_addr <= '0;
`endif
    end else begin
      case (state)
        ST_RST: begin
`ifdef MEM_CLEAR_EN
          state    <= ST_CLEAR;
          clr_addr <= '0;
`else
          state <= ST_RDY;
          ready <= 1'b1;
`endif
        end
`ifdef MEM_CLEAR_EN
        ST_CLEAR: begin
          mem[clr_addr] <= '0;
          if (clr_last) begin
            state <= ST_RDY;
            ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
`endif
        ST_RDY: begin
          if (accept) begin
            if (bus.wr_rd_i) begin
              if (in_range) mem[bus.addr_i] <= bus.wdata_i;
            end else begin
              rdata <= in_range ? mem[bus.addr_i] : '0;
            end
          end
        end
        default: begin
          state <= ST_RST;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata_o = rdata;
  assign bus.ready_o = ready;
endmodule

// File: tb/tb_mem_array.sv
// tb/tb_mem_array.sv - randomized self-checking bench for mem_array against a word-array model
module tb_mem_array;
  localparam int WIDTH = 16;
  localparam int DEPTH = 14;
  localparam int AW    = 4;
`ifdef MEM_CLEAR_EN
  localparam int RDY_EDGES = DEPTH + 1;
`else
  localparam int RDY_EDGES = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_array_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();
  mem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  bit started = 0;

  // Reference model: word array with per-word "known" flags, ready derived from edges since release.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_known [DEPTH];
  logic [WIDTH-1:0] m_rdata = '0;
  bit               m_rd_known = 1'b1;
  bit               m_ready = 1'b0;
  int               since = 0;

  initial for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b0; m_rdata = '0; m_rd_known = 1'b1; since = 0;
    end else begin
      if (bus.valid_i && m_ready) begin
        if (bus.wr_rd_i) begin
          if (int'(bus.addr_i) < DEPTH) begin
            m_mem[bus.addr_i] = bus.wdata_i; m_known[bus.addr_i] = 1'b1;
          end
        end else if (int'(bus.addr_i) < DEPTH) begin
          m_rdata = m_mem[bus.addr_i]; m_rd_known = m_known[bus.addr_i];
        end else begin
          m_rdata = '0; m_rd_known = 1'b1;
        end
      end
      if (since < 100000) since++;
`ifdef MEM_CLEAR_EN
      if (since == DEPTH + 1)
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1'b1; end
`endif
      m_ready = (since >= RDY_EDGES);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (bus.ready_o !== m_ready) begin
        errors++;
        $display("FAIL ready t=%0t actual=%b required=%b", $time, bus.ready_o, m_ready);
      end
      if (m_rd_known) begin
        checks++;
        if (bus.rdata_o !== m_rdata) begin
          errors++;
          $display("FAIL rdata t=%0t actual=%h required=%h", $time, bus.rdata_o, m_rdata);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input bit v, input bit w, input int a, input logic [WIDTH-1:0] d, input bit r);
    bus.valid_i = v; bus.wr_rd_i = w; bus.addr_i = AW'(a); bus.wdata_i = d; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic release_and_wait(input string name);
    int n;
    step(0, 0, 0, '0, 0);
    n = 1;
    while (!bus.ready_o && n < 200) begin
      step(0, 0, 0, '0, 0);
      n++;
    end
    chk(name, n, RDY_EDGES);
  endtask

  initial begin
    bus.valid_i = 0; bus.wr_rd_i = 0; bus.addr_i = '0; bus.wdata_i = '0;
    #2;
    step(1, 1, 3, 16'hDEAD, 1);
    step(1, 1, 3, 16'hDEAD, 1);
    started = 1;
    chk("reset_ready", bus.ready_o, 0);
    chk("reset_rdata", bus.rdata_o, 0);
    release_and_wait("release_latency");

    step(1, 1, 3, 16'hA5A5, 0);
    step(1, 0, 3, '0, 0);
    chk("read_a5a5", bus.rdata_o, 16'hA5A5);
    chk("model_a5a5", m_rdata, 16'hA5A5);
    step(1, 1, 4, 16'h1234, 0);
    chk("write_keeps_rdata", bus.rdata_o, 16'hA5A5);

    for (int a = 0; a < 16; a++) step(1, 1, a, WIDTH'(a * 16'h1111), 0);
    for (int a = 0; a < 16; a++) begin
      step(1, 0, a, '0, 0);
      chk($sformatf("sweep_rd%0d", a), bus.rdata_o, (a < DEPTH) ? a * 32'h1111 : 0);
    end

    step(0, 1, 5, 16'hFFFF, 0);
    step(0, 0, 0, '0, 0);
    step(1, 0, 5, '0, 0);
    chk("gated_write", bus.rdata_o, 16'h5555);

    step(1, 1, 7, 16'h7777, 0);
    step(1, 1, 8, 16'h8888, 0);
    step(1, 1, 7, 16'hBEEF, 1);
    step(1, 1, 7, 16'hBEEF, 1);
    chk("midreset_rdata", bus.rdata_o, 0);
    release_and_wait("rerelease_latency");
    step(1, 0, 7, '0, 0);
`ifdef MEM_CLEAR_EN
    chk("midreset_keep7", bus.rdata_o, 16'h0000);
`else
    chk("midreset_keep7", bus.rdata_o, 16'h7777);
`endif
    step(1, 0, 3, '0, 0);
`ifdef MEM_CLEAR_EN
    chk("reset_nowrite3", bus.rdata_o, 16'h0000);
`else
    chk("reset_nowrite3", bus.rdata_o, 16'h3333);
`endif

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
           WIDTH'($urandom), $urandom_range(0, 60) == 0);
    end
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, '0, 0);

    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_array.md
# mem_array

Single-port synchronous read/write memory with a valid/ready request interface. A requester drives an address, write data and a write/read select, then asserts `valid_i`. The block performs the write, or returns registered read data, when it accepts the request. It is the storage element exercised by the memory verification environment (`mem_intf` / `mem_env`) and is intended as a generic scratch RAM behind a simple bus master.

## Interface
- `WIDTH`, default 16: data word width in bits.
- `DEPTH`, default 16: number of words.
- `ADDR_WIDTH`, default 4: address width; must satisfy 2^ADDR_WIDTH >= DEPTH.

Ports:
- `clk_i`  in  1: single clock; all logic on rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `addr_i`  in  ADDR_WIDTH: word address of the request.
- `wdata_i`  in  WIDTH: write data, used when `wr_rd_i`=1.
- `wr_rd_i`  in  1: 1 = write, 0 = read.
- `valid_i`  in  1: request present.
- `rdata_o`  out  WIDTH: registered read data.
- `ready_o`  out  1: block can accept a request this cycle.

## Operation
- Handshake: a request is accepted at a rising edge where `valid_i`=1 and `ready_o`=1. Inputs are sampled only at acceptance. `valid_i` while `ready_o`=0 is ignored, so the requester must hold the request until it is accepted.
- Write accept: `mem[addr_i] <= wdata_i`; `rdata_o` is unchanged.
- Read accept: `rdata_o <= mem[addr_i]`. The value holds until the next accepted read or reset.
- Out-of-range address (`addr_i` >= DEPTH): a write is dropped and a read returns 0. The request is still accepted.
- Back-to-back requests are accepted every cycle while `ready_o`=1. A read of an address written in the previous cycle returns the new data.
- Storage is not affected by `rst_i` unless `MEM_CLEAR_EN` is defined. Contents are undefined at power-up.
- FSM states:
  - RST: entered whenever `rst_i`=1 at an edge, from any state.
  - CLEAR: present only with the macro.
  - RDY: serves requests.
- FSM transitions:
  - RST goes to RDY, or to CLEAR with the macro, at the first edge where `rst_i`=0.
  - CLEAR goes to RDY after its last address is written.
- Reset mid-operation: an in-progress cycle is abandoned and no write is committed on an edge where `rst_i`=1.

## Timing
- Reset values: `ready_o`=0 and `rdata_o`=0, applied at the first rising edge with `rst_i`=1 and held while `rst_i`=1.
- `ready_o` is registered. It rises at the first edge with `rst_i`=0, so the earliest acceptance is the second edge after reset release. Without the macro, `ready_o` then stays 1 until the next reset.
- Read latency is 1 cycle: for a read accepted at edge N, `rdata_o` is valid after edge N and can be sampled at edge N+1.
- Write latency is 1 cycle: the data is readable by a read accepted at edge N+1.
- `rdata_o` must not change on write acceptances or idle cycles.

## Configuration
- `MEM_CLEAR_EN` defined:
  - After reset release, the CLEAR state writes 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles).
  - `ready_o` stays 0 throughout and rises on the edge that completes the last clear write.
  - Reset asserted during CLEAR returns the FSM to RST, and the clear restarts from address 0 after release.
  - Reads after the clear return 0 until written.
- `MEM_CLEAR_EN` undefined:
  - The CLEAR state and the clear counter are absent.
  - Contents persist across reset.

## Test plan
- Reset: hold `rst_i`=1 for 2 cycles with `valid_i`=1 -> `ready_o`=0, `rdata_o`=0, no write committed. Release -> `ready_o`=1 one edge later (DEPTH+1 edges with `MEM_CLEAR_EN`).
- Write/read: write 0xA5A5 to addr 3, then read addr 3 -> `rdata_o`=0xA5A5 after the read edge. A following write to addr 4 leaves `rdata_o`=0xA5A5.
- Full sweep: write `addr*0x1111` to addrs 0..15 back-to-back, then read 0..15 back-to-back -> each value returned with 1-cycle latency and no stalls.
- Handshake gating: drive `valid_i`=0 with `wr_rd_i`=1 and `wdata_i`=0xFFFF to addr 5 -> a later read of addr 5 returns the prior value.
- Reset mid-stream: assert `rst_i` during a write burst -> the write on the reset edge is not committed. Without the macro, previously written words survive; with it, all reads return 0.
